alu_regfile_seq: RTL

Clocked, parametrised successor to the 8-bit accumulator ALU. It has an NREGS-entry signed register file and the same 16-opcode set, with explicit register addressing (rd, rs). A valid/ready issue handshake replaces the level-triggered enable. Shifts are variable-distance and iterative (one bit per cycle), which makes the block multi-cycle. It sits between the switch/button front-end (opcode, data_in) and the LED/7-segment display logic.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_core.sv | 63 ++++++
 rtl/alu_regfile_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle
// for the register-file ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_ASR  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_XNOR = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_NEG  = 4'hC;
  localparam logic [3:0] OP_MOVY = 4'hD;
  localparam logic [3:0] OP_SWAP = 4'hE;
  localparam logic [3:0] OP_LOAD = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational datapath: result
// and flags from opcode and operands A, B.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output flags_t           fl
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    y  = a;
    fl = '0;
    unique case (op)
      OP_ADD: begin
        y    = sum[M:0];
        fl.c = sum[WIDTH];
        fl.v = (a[M] == b[M]) && (y[M] != a[M]);
      end
      OP_SUB: begin
        y    = dif[M:0];
        fl.c = dif[WIDTH];
        fl.v = (a[M] != b[M]) && (y[M] != a[M]);
      end
      OP_CMP: begin
        if ($signed(a) > $signed(b))
          y = WIDTH'(1);
        else if ($signed(a) < $signed(b))
          y = '1;
        else
          y = '0;
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_NEG: begin
        y    = -a;
        fl.v = (a == {1'b1, {M{1'b0}}});
      end
      // zero-distance shifts and non-y ops pass A
      default: y = a;
    endcase
    fl.z = (y == '0);
    fl.n = y[M];
  end

endmodule

// File: rtl/alu_regfile_seq.sv
// Register-file ALU with valid/ready issue and
// iterative one-bit-per-cycle shifts.
module alu_regfile_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] led_a,
  output logic [WIDTH-1:0] led_b
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] a, b, y_c;
  logic [WIDTH-1:0] work, shifted;
  logic [SW-1:0]    amt, cnt;
  flags_t           fl_c, fl_q;
  state_t           state_q, state_d;
  logic             left, bout;
  logic             acc, start, last, noy;

  assign a     = rf[rd];
  assign b     = rf[rs];
  assign led_a = a;
  assign led_b = b;
  assign amt   = b[SW-1:0];

  assign op_ready = (state_q == S_IDLE);
  assign acc      = op_valid && op_ready;
  assign start    = acc && (amt != '0) &&
                    (opcode == OP_SHL || opcode == OP_ASR);
  assign noy      = (opcode == OP_MOVY) ||
                    (opcode == OP_SWAP) ||
                    (opcode == OP_LOAD);
  assign last     = (state_q == S_SHIFT) && (cnt == SW'(1));

  assign shifted = left ? {work[M-1:0], 1'b0}
                        : {work[M], work[M:1]};
  assign bout    = left ? work[M] : work[0];

  assign flag_z = fl_q.z;
  assign flag_n = fl_q.n;
  assign flag_c = fl_q.c;
  assign flag_v = fl_q.v;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op (opcode),
    .a  (a),
    .b  (b),
    .y  (y_c),
    .fl (fl_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      y       <= '0;
      fl_q    <= '0;
      y_valid <= 1'b0;
      work    <= '0;
      cnt     <= '0;
      left    <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (state_q == S_SHIFT) begin
        work <= shifted;
        cnt  <= cnt - SW'(1);
        if (last) begin
          y       <= shifted;
          fl_q    <= '{z: (shifted == '0), n: shifted[M],
                       c: bout, v: 1'b0};
          y_valid <= 1'b1;
        end
      end else if (acc) begin
        if (start) begin
          work <= a;
          cnt  <= amt;
          left <= (opcode == OP_SHL);
        end else if (!noy) begin
          y       <= y_c;
          fl_q    <= fl_c;
          y_valid <= 1'b1;
        end
        unique case (opcode)
          OP_MOVY: rf[rd] <= y;
          OP_LOAD: rf[rd] <= data_in;
          OP_SWAP: begin
            rf[rd] <= b;
            rf[rs] <= a;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
